// File: rtl/alu_req_sched_pkg.sv
// Shared definitions for the two-port ALU request scheduler.
//   DATA_W        default operand/result width
//   OP_*          ALU op codes; any other code is illegal
//   state_t       scheduler FSM encoding
package alu_pkg;
  localparam int DATA_W = 8;

  localparam logic [3:0] OP_PASS = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8;
  localparam logic [3:0] OP_GT   = 4'd9;
  localparam logic [3:0] OP_LT   = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_req_sched_if.sv
// Request/result bus of the ALU scheduler.
//   master : requester/consumer side (drives req_*, res_ready)
//   slave  : scheduler side (drives req_ready, res_*, busy, op_count)
// Per-port fields are packed {p1,p0}.
interface alu_req_sched_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][3:0]        req_ctrl;
  logic [1:0][DATA_W-1:0] req_a;
  logic [1:0][DATA_W-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [DATA_W-1:0]      res_data;
  logic                   res_src;
  logic                   res_err;
  logic                   busy;
  logic [CNT_W-1:0]       op_count;

  modport master (
    output req_valid, req_ctrl, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_src, res_err, busy, op_count
  );

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_src, res_err, busy, op_count
  );
endinterface

// File: rtl/alu_req_sched_core.sv
// alu8_core: pure combinational signed ALU/compare unit.
//   ctrl : op code (see alu_pkg OP_*)
//   a, b : signed two's complement operands
//   data : result (0 for illegal op codes); compares give 1/0
//   err  : op code illegal
module alu8_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   ctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] data,
  output logic         err
);
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (ctrl)
      OP_PASS: data = a;
      OP_INC:  data = a + W'(1);   // wraps mod 2^W
      OP_DEC:  data = a - W'(1);
      OP_NOT:  data = ~a;
      OP_NOR:  data = ~(a | b);
      OP_XOR:  data = a ^ b;
      OP_XNOR: data = ~(a ^ b);
      OP_GT:   data = {{(W-1){1'b0}}, ($signed(a) >  $signed(b))};
      OP_LT:   data = {{(W-1){1'b0}}, ($signed(a) <  $signed(b))};
      OP_EQ:   data = {{(W-1){1'b0}}, (a == b)};
      default: err  = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_req_sched.sv
// alu_req_sched: shares one ALU between two requesters.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of alu_req_sched_if (requests in, results out)
// Round-robin grant, registered op capture, registered result held under
// backpressure. Accept at cycle N gives res_valid at N+2; a pending request
// is accepted in the same cycle a result is consumed.
module alu_req_sched #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_req_sched_if.slave bus
);
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              src;
  } op_t;

  state_t            state;
  logic              rr_ptr;
  op_t               op_q, op_in;
  logic              any_req, win, accept;
  logic [DATA_W-1:0] alu_data, res_data_q;
  logic              alu_err, res_err_q, res_src_q, res_valid_q;
  logic [CNT_W-1:0]  op_count_q;

  // Contention goes to rr_ptr; a lone requester always wins.
  always_comb begin
    any_req = |bus.req_valid;
    win     = (&bus.req_valid) ? rr_ptr : bus.req_valid[1];
    accept  = any_req && !rst &&
              ((state == ST_IDLE) || (state == ST_DONE && bus.res_ready));
    op_in   = '{ctrl: bus.req_ctrl[win], a: bus.req_a[win],
                b: bus.req_b[win], src: win};
  end

  assign bus.req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_src   = res_src_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.op_count  = op_count_q;

  alu8_core #(.W(DATA_W)) u_alu (
    .ctrl (op_q.ctrl),
    .a    (op_q.a),
    .b    (op_q.b),
    .data (alu_data),
    .err  (alu_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_src_q   <= 1'b0;
      res_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= op_in;
            rr_ptr <= ~win;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data_q  <= alu_data;
          res_err_q   <= alu_err;
          res_src_q   <= op_q.src;
          res_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            op_count_q  <= op_count_q + CNT_W'(1);
            // Drop valid even when chaining, so the consumed result is
            // never presented twice while the next op executes.
            res_valid_q <= 1'b0;
            if (accept) begin
              op_q   <= op_in;
              rr_ptr <= ~win;
              state  <= ST_EXEC;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_sched.sv
// Directed self-checking bench for alu_req_sched.
module tb_alu_req_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  alu_req_sched_if #(.DATA_W(8), .CNT_W(8)) bus ();

  alu_req_sched #(.DATA_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.req_ctrl  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Issue one op on port p and consume its result; reports captured outputs.
  task automatic run_op(input int p, input logic [3:0] c, input logic [7:0] a,
                        input logic [7:0] b, output logic [7:0] d,
                        output logic s, output logic e, output logic to);
    int n;
    to = 1'b0;
    bus.req_ctrl[p] = c;
    bus.req_a[p]    = a;
    bus.req_b[p]    = b;
    bus.req_valid[p] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[p] && n < 20) begin tick(); n++; end
    if (n >= 20) to = 1'b1;
    tick();
    bus.req_valid[p] = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 20) begin tick(); n++; end
    if (n >= 20) to = 1'b1;
    d = bus.res_data;
    s = bus.res_src;
    e = bus.res_err;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req_valid = 2'b01;
    #3;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b exp 00", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b exp 0", bus.res_valid); end
    checks++; if ({bus.res_data, bus.res_src, bus.res_err} !== 10'h0) begin errors++; $display("FAIL rst_res: got %h/%b/%b exp 00/0/0", bus.res_data, bus.res_src, bus.res_err); end
    checks++; if (bus.busy !== 1'b0 || bus.op_count !== 8'd0) begin errors++; $display("FAIL rst_busy_cnt: got %b/%0d exp 0/0", bus.busy, bus.op_count); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    bus.req_ctrl[0] = 4'd3;
    bus.req_a[0]    = 8'h7F;
    bus.req_valid   = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL t1_grant: got %b exp 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL t1_exec: got valid %b busy %b exp 0 1", bus.res_valid, bus.busy); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h80 || bus.res_src !== 1'b0 || bus.res_err !== 1'b0)
      begin errors++; $display("FAIL t1_result: got v%b d%h s%b e%b exp v1 d80 s0 e0", bus.res_valid, bus.res_data, bus.res_src, bus.res_err); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++; if (bus.res_valid !== 1'b0 || bus.op_count !== 8'd1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL t1_consume: got v%b cnt%0d busy%b exp v0 cnt1 busy0", bus.res_valid, bus.op_count, bus.busy); end
  endtask

  task automatic test_rr_both();
    do_reset();
    bus.req_ctrl[0] = 4'd9;  bus.req_a[0] = 8'd5; bus.req_b[0] = 8'hFD;
    bus.req_ctrl[1] = 4'd10; bus.req_a[1] = 8'd5; bus.req_b[1] = 8'hFD;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL t2_grant0: got %b exp 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b10;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL t2_exec_ready: got %b exp 00", bus.req_ready); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h01 || bus.res_src !== 1'b0)
      begin errors++; $display("FAIL t2_res0: got v%b d%h s%b exp v1 d01 s0", bus.res_valid, bus.res_data, bus.res_src); end
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL t2_grant1: got %b exp 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h00 || bus.res_src !== 1'b1)
      begin errors++; $display("FAIL t2_res1: got v%b d%h s%b exp v1 d00 s1", bus.res_valid, bus.res_data, bus.res_src); end
    tick();
    bus.res_ready = 1'b0;
    checks++; if (bus.op_count !== 8'd2 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL t2_count: got %0d v%b exp 2 v0", bus.op_count, bus.res_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_ctrl[0] = 4'd7; bus.req_a[0] = 8'h0F; bus.req_b[0] = 8'hFF;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.req_ctrl[1] = 4'd2; bus.req_a[1] = 8'h33;
    bus.req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL t3_ready_c%0d: got %b exp 00", i, bus.req_ready); end
      checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'hF0 || bus.res_src !== 1'b0 || bus.res_err !== 1'b0 || bus.op_count !== 8'd0)
        begin errors++; $display("FAIL t3_hold_c%0d: got v%b d%h s%b e%b cnt%0d exp v1 dF0 s0 e0 cnt0", i, bus.res_valid, bus.res_data, bus.res_src, bus.res_err, bus.op_count); end
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL t3_chain_grant: got %b exp 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    checks++; if (bus.op_count !== 8'd1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL t3_cnt1: got %0d v%b exp 1 v0", bus.op_count, bus.res_valid); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h33 || bus.res_src !== 1'b1)
      begin errors++; $display("FAIL t3_res2: got v%b d%h s%b exp v1 d33 s1", bus.res_valid, bus.res_data, bus.res_src); end
    tick();
    bus.res_ready = 1'b0;
    checks++; if (bus.op_count !== 8'd2) begin errors++; $display("FAIL t3_cnt2: got %0d exp 2", bus.op_count); end
  endtask

  task automatic test_illegal();
    logic [7:0] d; logic s, e, to;
    logic [3:0] ctl [3] = '{4'd0, 4'd15, 4'd11};
    logic [7:0] op_a [3] = '{8'hFF, 8'hFF, 8'h80};
    logic [7:0] op_b [3] = '{8'h00, 8'h00, 8'h80};
    logic [7:0] exp_d [3] = '{8'h00, 8'h00, 8'h01};
    logic exp_e [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_op(1, ctl[i], op_a[i], op_b[i], d, s, e, to);
      checks++; if (to || d !== exp_d[i] || e !== exp_e[i] || s !== 1'b1)
        begin errors++; $display("FAIL t4_op%0d: got d%h e%b s%b to%b exp d%h e%b s1 to0", ctl[i], d, e, s, to, exp_d[i], exp_e[i]); end
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] d; logic s, e, to;
    do_reset();
    run_op(0, 4'd2, 8'h11, 8'h00, d, s, e, to);
    bus.req_ctrl[0] = 4'd3; bus.req_a[0] = 8'h01;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    checks++; if (bus.busy !== 1'b1 || bus.op_count !== 8'd1) begin errors++; $display("FAIL t5_pre_exec: got busy%b cnt%0d exp 1 1", bus.busy, bus.op_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.op_count !== 8'd0)
      begin errors++; $display("FAIL t5_rst_exec: got busy%b v%b cnt%0d exp 0 0 0", bus.busy, bus.res_valid, bus.op_count); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL t5_post_exec: got v%b busy%b exp 0 0", bus.res_valid, bus.busy); end
    run_op(0, 4'd2, 8'h11, 8'h00, d, s, e, to);
    bus.req_ctrl[1] = 4'd0; bus.req_a[1] = 8'h22;
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_src !== 1'b1 || bus.res_err !== 1'b1)
      begin errors++; $display("FAIL t5_pre_done: got v%b s%b e%b exp 1 1 1", bus.res_valid, bus.res_src, bus.res_err); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || {bus.res_data, bus.res_src, bus.res_err} !== 10'h0 || bus.busy !== 1'b0 || bus.op_count !== 8'd0)
      begin errors++; $display("FAIL t5_rst_done: got v%b d%h s%b e%b busy%b cnt%0d exp all 0", bus.res_valid, bus.res_data, bus.res_src, bus.res_err, bus.busy, bus.op_count); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL t5_post_done: got v%b exp 0", bus.res_valid); end
    run_op(0, 4'd4, 8'h80, 8'h00, d, s, e, to);
    checks++; if (to || d !== 8'h7F || s !== 1'b0 || e !== 1'b0 || bus.op_count !== 8'd1)
      begin errors++; $display("FAIL t5_recover: got d%h s%b e%b cnt%0d to%b exp d7F s0 e0 cnt1 to0", d, s, e, bus.op_count, to); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    logic [1:0] exp_g;
    do_reset();
    bus.req_ctrl[0] = 4'd5; bus.req_a[0] = 8'h0F;
    bus.req_ctrl[1] = 4'd8; bus.req_a[1] = 8'h0F; bus.req_b[1] = 8'h0F;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL t6_first_grant: got %b exp 01", bus.req_ready); end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 2'b00)
        begin errors++; $display("FAIL t6_exec_k%0d: got v%b r%b exp v0 r00", k, bus.res_valid, bus.req_ready); end
      tick();
      exp_d = (k % 2 == 0) ? 8'hF0 : 8'hFF;
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if (bus.res_valid !== 1'b1 || bus.res_src !== k[0] || bus.res_data !== exp_d || bus.req_ready !== exp_g)
        begin errors++; $display("FAIL t6_done_k%0d: got v%b s%b d%h r%b exp v1 s%b d%h r%b", k, bus.res_valid, bus.res_src, bus.res_data, bus.req_ready, k[0], exp_d, exp_g); end
      tick();
    end
    checks++; if (bus.op_count !== 8'd8) begin errors++; $display("FAIL t6_count: got %0d exp 8", bus.op_count); end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_rr_both();
    test_backpressure();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
